// File: rtl/cache_mem_responder.sv
// cache_mem_responder: next-level memory model behind the cache's bus-operation
// interface. Each accepted non-NOP request is serviced against a small backing
// store with a fixed per-access latency. RW_OUT commits its write-back before it
// reads, and each such request returns exactly one response.
module cache_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_victim_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [1:0]        resp_op,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RW    = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_op;
  logic [IDX_W-1:0]    r_addr_idx;
  logic [IDX_W-1:0]    r_victim_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic [LAT_W-1:0]    r_lat;
  logic [DATA_W-1:0]   r_rdata;
  logic [CNT_W-1:0]    r_rd_cnt;
  logic [CNT_W-1:0]    r_wr_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic w_start;
  logic w_lat_done;
  logic w_wr_exit;
  logic w_rd_exit;
  logic w_unused;

  // Only the low index bits of either address select a word; upper bits alias.
  assign w_unused   = ^{req_addr[ADDR_W-1:IDX_W], req_victim_addr[ADDR_W-1:IDX_W]};

  // A NOP is accepted like any request but starts no memory work.
  assign w_start    = (r_state == S_IDLE) && req_valid && (req_op != OP_NOP);
  assign w_lat_done = (r_lat == '0);
  assign w_wr_exit  = (r_state == S_WR) && w_lat_done;
  assign w_rd_exit  = (r_state == S_RD) && w_lat_done;

  assign resp_op    = r_op;
  assign resp_rdata = r_rdata;
  assign rd_cnt     = r_rd_cnt;
  assign wr_cnt     = r_wr_cnt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; RW_OUT passes through WR and then RD.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_start) begin
          w_state_next = (req_op == OP_READ) ? S_RD : S_WR;
        end
      end
      S_WR: begin
        if (w_lat_done) begin
          w_state_next = (r_op == OP_RW) ? S_RD : S_RESP;
        end
      end
      S_RD: begin
        if (w_lat_done) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request capture, latency down-counter, read data and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op         <= OP_NOP;
      r_addr_idx   <= '0;
      r_victim_idx <= '0;
      r_wdata      <= '0;
      r_lat        <= '0;
      r_rdata      <= '0;
      r_rd_cnt     <= '0;
      r_wr_cnt     <= '0;
    end else begin
      if (w_start) begin
        r_op         <= req_op;
        r_addr_idx   <= req_addr[IDX_W-1:0];
        r_victim_idx <= req_victim_addr[IDX_W-1:0];
        r_wdata      <= req_wdata;
        r_lat        <= LAT_W'(LATENCY - 1);
        r_rdata      <= '0;
      end else if (r_state == S_WR) begin
        if (w_lat_done) begin
          r_wr_cnt <= r_wr_cnt + CNT_W'(1);
          // Reload for the read phase of RW_OUT; harmless otherwise.
          r_lat    <= LAT_W'(LATENCY - 1);
        end else begin
          r_lat <= r_lat - LAT_W'(1);
        end
      end else if (r_state == S_RD) begin
        if (w_lat_done) begin
          r_rdata  <= r_mem[r_addr_idx];
          r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        end else begin
          r_lat <= r_lat - LAT_W'(1);
        end
      end
    end
  end

  // Backing store: cleared on reset, written only at the end of a WR phase,
  // so an aborted write never lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_exit) begin
      r_mem[r_victim_idx] <= r_wdata;
    end
  end

  // Reads are only issued after the write phase has fully committed.
  logic w_rd_after_wr_unused;
  assign w_rd_after_wr_unused = w_rd_exit;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: a table of directed requests,
// hand-written reset-abort sequences, then random requests checked against a
// word-array memory model with read/write tallies.
module tb_cache_mem_responder;

  localparam int LAT = 4;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, RW = 2'd2, NP = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_victim_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_op;
  logic [31:0] resp_rdata;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  cache_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(256), .LATENCY(LAT), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_victim_addr(req_victim_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
    .resp_rdata(resp_rdata), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain word array plus access tallies.
  logic [31:0] m_mem [256];
  int          m_rd;
  int          m_wr;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] victim;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          hold;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    m_rd = 0;
    m_wr = 0;
  endtask

  // Issue one request starting at a negedge in IDLE, wait for its response,
  // optionally stall the consumer for 'hold' cycles with a competing request
  // pending, then complete the handshake. Ends on a negedge.
  task automatic run_txn(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] victim, input logic [31:0] wdata,
                         input int hold, input string name, output logic [31:0] got);
    logic [31:0] exp_rd;
    int          exp_lat;
    int          n;
    bit          seen;
    got = '0;
    chk({name, " req_ready"}, 64'(req_ready), 64'd1);
    req_valid       = 1'b1;
    req_op          = op;
    req_addr        = addr;
    req_victim_addr = victim;
    req_wdata       = wdata;
    @(posedge clk);
    #1;
    req_valid       = 1'b0;
    req_op          = 2'($urandom_range(0, 3));
    req_addr        = $urandom;
    req_victim_addr = $urandom;
    req_wdata       = $urandom;
    // Model: write-back first, then read, both modulo 256 words.
    exp_rd  = '0;
    exp_lat = 0;
    if (op == WR || op == RW) begin
      m_mem[victim[7:0]] = wdata;
      m_wr++;
      exp_lat += LAT;
    end
    if (op == RD || op == RW) begin
      exp_rd = m_mem[addr[7:0]];
      m_rd++;
      exp_lat += LAT;
    end
    if (op == NP) begin
      seen = 0;
      for (int i = 0; i < 2 * LAT + 2; i++) begin
        if (resp_valid || !req_ready) seen = 1;
        @(posedge clk);
        #1;
      end
      chk({name, " nop no resp"}, 64'(seen), 64'd0);
    end else begin
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!resp_valid && n < 4 * LAT + 8);
      chk({name, " latency"}, 64'(n), 64'(exp_lat));
      chk({name, " resp_op"}, 64'(resp_op), 64'(op));
      chk({name, " rdata"}, 64'(resp_rdata), 64'(exp_rd));
      chk({name, " busy"}, 64'(req_ready), 64'd0);
      got = resp_rdata;
      if (hold > 0) begin
        req_valid = 1'b1;
        req_op    = RD;
        for (int i = 0; i < hold; i++) begin
          @(posedge clk);
          #1;
          chk({name, " hold valid"}, 64'(resp_valid), 64'd1);
          chk({name, " hold op"}, 64'(resp_op), 64'(op));
          chk({name, " hold rdata"}, 64'(resp_rdata), 64'(exp_rd));
          chk({name, " hold no accept"}, 64'(req_ready), 64'd0);
        end
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk({name, " resp drop"}, 64'(resp_valid), 64'd0);
      chk({name, " ready again"}, 64'(req_ready), 64'd1);
    end
    chk({name, " rd_cnt"}, 64'(rd_cnt), 64'(m_rd & 32'hFFFF));
    chk({name, " wr_cnt"}, 64'(wr_cnt), 64'(m_wr & 32'hFFFF));
    $display("txn %s op=%0d addr=%0h victim=%0h wdata=%0h rdata=%0h", name, op, addr, victim, wdata, got);
    @(negedge clk);
  endtask

  // Start a request, then pulse reset during cycle 2 of its first phase.
  task automatic abort_txn(input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] victim, input logic [31:0] wdata,
                           input string name);
    bit seen;
    req_valid       = 1'b1;
    req_op          = op;
    req_addr        = addr;
    req_victim_addr = victim;
    req_wdata       = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk({name, " resp in reset"}, 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    seen = 0;
    for (int i = 0; i < 2 * LAT + 2; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1;
    end
    chk({name, " never resp"}, 64'(seen), 64'd0);
    chk({name, " rd_cnt zero"}, 64'(rd_cnt), 64'd0);
    chk({name, " wr_cnt zero"}, 64'(wr_cnt), 64'd0);
    chk({name, " idle"}, 64'(req_ready), 64'd1);
    $display("txn %s aborted op=%0d", name, op);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] got;
    logic [1:0]  rop;
    logic [31:0] raddr;
    logic [31:0] rvic;

    vecs[0] = '{RD, 32'h10,  32'h0,   32'h0,        32'h0,        0};
    vecs[1] = '{WR, 32'h0,   32'h05,  32'hDEADBEEF, 32'h0,        0};
    vecs[2] = '{RD, 32'h05,  32'h0,   32'h0,        32'hDEADBEEF, 0};
    vecs[3] = '{RW, 32'h07,  32'h07,  32'h0BEEFA55, 32'h0BEEFA55, 0};
    vecs[4] = '{NP, 32'h05,  32'h05,  32'h11111111, 32'h0,        0};
    vecs[5] = '{WR, 32'h0,   32'h105, 32'h1234,     32'h0,        0};
    vecs[6] = '{RD, 32'h005, 32'h0,   32'h0,        32'h1234,     0};
    vecs[7] = '{WR, 32'h0,   32'h20,  32'hCAFE0001, 32'h0,        5};
    vecs[8] = '{RD, 32'h20,  32'h0,   32'h0,        32'hCAFE0001, 0};

    reset           = 1'b1;
    req_valid       = 1'b0;
    resp_ready      = 1'b0;
    req_op          = NP;
    req_addr        = '0;
    req_victim_addr = '0;
    req_wdata       = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset resp_op", 64'(resp_op), 64'(NP));
    chk("reset resp_rdata", 64'(resp_rdata), 64'd0);
    chk("reset rd_cnt", 64'(rd_cnt), 64'd0);
    chk("reset wr_cnt", 64'(wr_cnt), 64'd0);
    @(negedge clk);

    // Directed table; entry 7 stalls the consumer and entry 8 must be
    // accepted on the first edge after the handshake.
    for (int v = 0; v < 9; v++) begin
      run_txn(vecs[v].op, vecs[v].addr, vecs[v].victim, vecs[v].wdata,
              vecs[v].hold, $sformatf("vec%0d", v), got);
      if (vecs[v].op != NP) chk($sformatf("vec%0d table rdata", v), 64'(got), 64'(vecs[v].exp_rdata));
    end

    // Reset during RD, then during WR; the aborted write must not land.
    abort_txn(RD, 32'h05, 32'h0, 32'h0, "abort_rd");
    abort_txn(WR, 32'h0, 32'h30, 32'h55AA55AA, "abort_wr");
    run_txn(RD, 32'h30, 32'h0, 32'h0, 0, "post_abort_rd", got);
    chk("post_abort table rdata", 64'(got), 64'd0);
    run_txn(RD, 32'h05, 32'h0, 32'h0, 0, "cleared_rd", got);
    chk("cleared table rdata", 64'(got), 64'd0);

    // Random traffic over a handful of aliased indices.
    for (int t = 0; t < 40; t++) begin
      rop   = 2'($urandom_range(0, 3));
      raddr = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7));
      rvic  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 7));
      run_txn(rop, raddr, rvic, $urandom, (t == 39) ? 0 : int'($urandom_range(0, 2)),
              $sformatf("rnd%0d", t), got);
    end

    req_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
